md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
- Parametrised successor to the single-cycle ALU control decoder, placed in the EX stage of the pipelined MIPS core.
- Adds multiply/divide support: decodes R-type mult/multu/div/divu/mfhi/mflo/mthi/mtlo funct codes.
- Runs a multi-cycle busy counter whose latency is set per operation class.
- Owns the HI/LO registers and raises a stall request while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  EX-stage instruction is valid.
- alu_op  in  2  main-decoder ALU op; 2'b11 = R-type funct decode.
- funct  in  6  instruction funct field.
- rs_val  in  WIDTH  forwarded rs operand.
- rt_val  in  WIDTH  forwarded rt operand.
- busy  out  1  an operation is in flight.
- start  out  1  combinational; a mult/div is accepted this cycle.
- stall_req  out  1  combinational; hold the pipeline this cycle.
- md_read  out  1  combinational; the current instruction is mfhi/mflo.
- md_rdata  out  WIDTH  HI on mfhi, LO on mflo, else 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Decode:
  - is_md = instr_valid && alu_op==2'b11 && funct in {0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu}.
  - Other funct values are ignored by this block.
- States: IDLE (cnt==0) and BUSY (cnt!=0). busy = (cnt != 0).
- stall_req = is_md && busy. A stalled instruction is not accepted and has no side effect.
- Accept in IDLE:
  - start = is_md && !busy && funct in {mult, multu, div, divu}.
  - On the accept edge: cnt loads MULT_CYCLES or DIV_CYCLES; operands and op code are latched.
  - The result may be computed at accept or at commit, but it must depend only on the latched operands.
- Countdown: cnt decrements once per cycle. On the edge where cnt goes 1->0, HI/LO commit.
  - Net effect: busy is high for exactly L cycles after the accept edge.
  - New HI/LO are visible in the first cycle busy is low.
- Arithmetic:
  - mult: signed 2*WIDTH product; multu: unsigned. {HI,LO} = product.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. divu: unsigned.
  - Divisor 0: HI and LO unchanged; the full DIV_CYCLES busy period still occurs.
  - Signed MIN / -1: LO = MIN, HI = 0.
- mthi/mtlo in IDLE: HI (mthi) or LO (mtlo) <= rs_val on the same edge; no busy period.
- mfhi/mflo in IDLE: md_rdata reflects the current HI/LO combinationally. If busy, they stall; no stale read is ever returned.
- Reset (async, active-low), including mid-operation:
  - cnt=0, hi=0, lo=0, latched operands=0; any pending result is discarded.
  - All outputs read 0 while reset is asserted.
- Back-to-back: a second mult/div presented in the cycle busy falls is accepted that cycle (start=1, stall_req=0).

Decomposition:
- Shared macro header, alongside the existing ALU funct codes: funct codes for mfhi/mthi/mflo/mtlo/mult/multu/div/divu, plus a 2-bit md op encoding (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
- One sub-module md_arith: purely combinational, takes op, a, b and produces hi_res/lo_res, including the div-by-zero flag and MIN/-1 handling.
- Counter, HI/LO registers and decode stay in md_unit_ctrl.

Test Plan:
- mult rs=0xFFFFFFFE (-2), rt=3 -> start=1 for one cycle; busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu rs=100, rt=7 -> busy 10 cycles; then lo=14, hi=2. div rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div with rt=0 after mthi 0x1234 / mtlo 0x5678 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged. div 0x80000000 / -1 -> lo=0x80000000, hi=0.
- mflo presented during the 3rd busy cycle -> stall_req=1 until busy drops; first non-stalled cycle md_rdata = the new LO.
- Assert reset in the 2nd busy cycle of a multu -> busy=0, hi=lo=0 immediately; no commit after reset release.
- Non-md funct (addu 0x21) with alu_op=2'b11 -> start=0, stall_req=0, md_read=0, md_rdata=0; HI/LO unchanged.

Source files
------------

// File: rtl/md_unit_ctrl_pkg.sv
// Shared funct codes and multiply/divide op encoding for the EX-stage control decoders.
package md_unit_ctrl_pkg;

   localparam logic [1:0] ALU_OP_RTYPE = 2'b11;

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
   localparam logic [5:0] FUNCT_ADDU  = 6'h21;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   function automatic md_op_e funct_to_op(logic [5:0] f);
      md_op_e op;
      case (f)
         FUNCT_MULTU: op = MD_MULTU;
         FUNCT_DIV:   op = MD_DIV;
         FUNCT_DIVU:  op = MD_DIVU;
         default:     op = MD_MULT;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing HI/LO results for one latched operation.
module md_arith
   import md_unit_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res,
   output logic             div_zero
);

   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

   // Sign-extending to 2*WIDTH makes the truncated unsigned product equal the signed one.
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

   assign a_neg = (op == MD_DIV) && a[WIDTH-1];
   assign b_neg = (op == MD_DIV) && b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // MIN / -1 needs no special case: |MIN| is representable unsigned and negates back to MIN.
   assign divisor = (b == '0) ? WIDTH'(1) : b_mag;
   assign q_mag   = a_mag / divisor;
   assign r_mag   = a_mag % divisor;
   assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem     = a_neg ? -r_mag : r_mag;

   assign div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == '0);

   always_comb begin
      hi_res = rem;
      lo_res = quot;
      case (op)
         MD_MULT:  {hi_res, lo_res} = prod_s;
         MD_MULTU: {hi_res, lo_res} = prod_u;
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit_ctrl.sv
// EX-stage multiply/divide controller: decodes md funct codes, runs the busy countdown,
// owns HI/LO and requests a pipeline stall while an operation is in flight.
module md_unit_ctrl
   import md_unit_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             start,
   output logic             stall_req,
   output logic             md_read,
   output logic [WIDTH-1:0] md_rdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic             is_md_funct, is_muldiv, is_md, idle_md, is_div;
   logic [WIDTH-1:0] hi_res, lo_res;
   logic             div_zero;

   always_comb begin
      is_md_funct = 1'b0;
      is_muldiv   = 1'b0;
      case (funct)
         FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO: is_md_funct = 1'b1;
         FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
            is_md_funct = 1'b1;
            is_muldiv   = 1'b1;
         end
         default: ;
      endcase
   end

   // Gated by reset so the combinational outputs also read 0 while reset is held.
   assign is_md     = reset && instr_valid && (alu_op == ALU_OP_RTYPE) && is_md_funct;
   assign busy      = (cnt_q != '0);
   assign idle_md   = is_md && !busy;
   assign start     = idle_md && is_muldiv;
   assign stall_req = is_md && busy;
   assign md_read   = idle_md && ((funct == FUNCT_MFHI) || (funct == FUNCT_MFLO));
   assign md_rdata  = !md_read ? '0 : (funct == FUNCT_MFHI) ? hi_q : lo_q;
   assign is_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
   assign hi        = hi_q;
   assign lo        = lo_q;

   md_arith #(
      .WIDTH (WIDTH)
   ) u_md_arith (
      .op       (op_q),
      .a        (a_q),
      .b        (b_q),
      .hi_res   (hi_res),
      .lo_res   (lo_res),
      .div_zero (div_zero)
   );

   always_comb begin
      cnt_d = cnt_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      if (start) begin
         cnt_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         op_d  = funct_to_op(funct);
         a_d   = rs_val;
         b_d   = rt_val;
      end else if (busy) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      // Commit on the 1->0 edge; a zero divisor still burns the full busy period.
      if ((cnt_q == CNT_W'(1)) && !div_zero) begin
         hi_d = hi_res;
         lo_d = lo_res;
      end
      if (idle_md && (funct == FUNCT_MTHI)) hi_d = rs_val;
      if (idle_md && (funct == FUNCT_MTLO)) lo_d = rs_val;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         a_q   <= a_d;
         b_q   <= b_d;
         op_q  <= op_d;
      end
   end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl with hand-computed HI/LO and busy-length expectations.
module tb_md_unit_ctrl;
   import md_unit_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] rs_val, rt_val;
   logic        busy, start, stall_req, md_read;
   logic [31:0] md_rdata, hi, lo;

   int errors = 0;
   int checks = 0;
   int n;

   always #5 clk = ~clk;

   md_unit_ctrl #(
      .WIDTH       (32),
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10),
      .CNT_W       (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .alu_op      (alu_op),
      .funct       (funct),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .busy        (busy),
      .start       (start),
      .stall_req   (stall_req),
      .md_read     (md_read),
      .md_rdata    (md_rdata),
      .hi          (hi),
      .lo          (lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic present(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
      instr_valid = 1'b1;
      alu_op      = 2'b11;
      funct       = f;
      rs_val      = rs;
      rt_val      = rt;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] rs,
                         input logic [31:0] rt, input int lat, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      int cnt;
      present(f, rs, rt);
      #1;
      check({tag, "_start"}, start, 1);
      check({tag, "_stall"}, stall_req, 0);
      next_cycle();
      instr_valid = 1'b0;
      cnt = 0;
      while (busy && cnt < lat + 5) begin
         cnt++;
         next_cycle();
      end
      check({tag, "_busy_len"}, cnt, lat);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
   endtask

   task automatic set_reg(input string tag, input logic [5:0] f, input logic [31:0] val);
      present(f, val, 32'h0);
      #1;
      check({tag, "_start"}, start, 0);
      next_cycle();
      instr_valid = 1'b0;
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      present(FUNCT_MULT, 32'd5, 32'd3);
      #2;
      check("rst_busy", busy, 0);
      check("rst_start", start, 0);
      check("rst_stall", stall_req, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      funct = FUNCT_MFHI;
      #1;
      check("rst_md_read", md_read, 0);
      check("rst_md_rdata", md_rdata, 0);
      next_cycle();
      reset       = 1'b1;
      instr_valid = 1'b0;
      next_cycle();
      check("post_rst_busy", busy, 0);

      run_op("mult", FUNCT_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op("divu", FUNCT_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
      run_op("div_neg", FUNCT_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);

      set_reg("mthi", FUNCT_MTHI, 32'h1234);
      set_reg("mtlo", FUNCT_MTLO, 32'h5678);
      check("mt_hi", hi, 32'h1234);
      check("mt_lo", lo, 32'h5678);
      present(FUNCT_MFHI, 32'h0, 32'h0);
      #1;
      check("mfhi_read", md_read, 1);
      check("mfhi_data", md_rdata, 32'h1234);
      present(FUNCT_MFLO, 32'h0, 32'h0);
      #1;
      check("mflo_data", md_rdata, 32'h5678);
      next_cycle();
      instr_valid = 1'b0;

      run_op("div_zero", FUNCT_DIV, 32'd5, 32'd0, 10, 32'h1234, 32'h5678);
      run_op("div_min", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

      // mflo arriving in the 3rd busy cycle of mult 3*5
      present(FUNCT_MULT, 32'd3, 32'd5);
      #1;
      check("mflo_stall_start", start, 1);
      next_cycle();
      instr_valid = 1'b0;
      next_cycle();
      next_cycle();
      present(FUNCT_MFLO, 32'h0, 32'h0);
      #1;
      n = 0;
      while (busy && n < 10) begin
         check("mflo_stalled", stall_req, 1);
         check("mflo_stalled_data", md_rdata, 0);
         n++;
         next_cycle();
      end
      check("mflo_stall_len", n, 3);
      check("mflo_unstall", stall_req, 0);
      check("mflo_read", md_read, 1);
      check("mflo_new_lo", md_rdata, 32'd15);
      instr_valid = 1'b0;

      // back-to-back: divu 9/2 held until mult 6*7 finishes
      present(FUNCT_MULT, 32'd6, 32'd7);
      #1;
      check("b2b_start1", start, 1);
      next_cycle();
      present(FUNCT_DIVU, 32'd9, 32'd2);
      n = 0;
      while (busy && n < 10) begin
         check("b2b_stall", stall_req, 1);
         check("b2b_no_start", start, 0);
         n++;
         next_cycle();
      end
      check("b2b_len", n, 5);
      check("b2b_start2", start, 1);
      check("b2b_stall_low", stall_req, 0);
      check("b2b_mult_lo", lo, 32'd42);
      check("b2b_mult_hi", hi, 32'd0);
      next_cycle();
      instr_valid = 1'b0;
      n = 0;
      while (busy && n < 15) begin
         n++;
         next_cycle();
      end
      check("b2b_divu_len", n, 10);
      check("b2b_divu_hi", hi, 32'd1);
      check("b2b_divu_lo", lo, 32'd4);

      // reset in the 2nd busy cycle of multu discards the result
      present(FUNCT_MULTU, 32'hFFFFFFFF, 32'd2);
      #1;
      check("rstmid_start", start, 1);
      next_cycle();
      instr_valid = 1'b0;
      next_cycle();
      reset = 1'b0;
      #1;
      check("rstmid_busy", busy, 0);
      check("rstmid_hi", hi, 0);
      check("rstmid_lo", lo, 0);
      next_cycle();
      reset = 1'b1;
      repeat (8) next_cycle();
      check("rstmid_after_busy", busy, 0);
      check("rstmid_after_hi", hi, 0);
      check("rstmid_after_lo", lo, 0);

      // non-md funct is ignored
      set_reg("mthi2", FUNCT_MTHI, 32'hAAAA);
      set_reg("mtlo2", FUNCT_MTLO, 32'hBBBB);
      present(FUNCT_ADDU, 32'd1, 32'd2);
      #1;
      check("addu_start", start, 0);
      check("addu_stall", stall_req, 0);
      check("addu_md_read", md_read, 0);
      check("addu_md_rdata", md_rdata, 0);
      next_cycle();
      instr_valid = 1'b0;
      check("addu_busy", busy, 0);
      check("addu_hi", hi, 32'hAAAA);
      check("addu_lo", lo, 32'hBBBB);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
